// File: rtl/regfile_2r1w_onehot.sv
// 32x32 register file, two registered read ports, one write port driven by a
// one-hot select vector. Register 0 reads as zero and ignores writes.
// Malformed selects (zero-hot or multi-hot) are rejected and flagged.
// Optional macro REGFILE_WRITE_BYPASS_EN: a read that collides with a valid
// write in the same edge captures the incoming write data.

module regfile_2r1w_onehot #(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned NREGS   = 32,
    parameter int unsigned RADDR_W = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               we,
    input  logic [NREGS-1:0]   wsel,
    input  logic [DATA_W-1:0]  wdata,
    input  logic [RADDR_W-1:0] raddr1,
    input  logic [RADDR_W-1:0] raddr2,
    output logic [DATA_W-1:0]  rdata1,
    output logic [DATA_W-1:0]  rdata2,
    output logic               wr_err,
    output logic               err_sticky,
    input  logic               err_clr
);

    localparam logic [NREGS-1:0] SelOne = NREGS'(1);

    logic [DATA_W-1:0] regs_q [NREGS];
    logic [DATA_W-1:0] rdata1_q, rdata2_q;
    logic [DATA_W-1:0] rdata1_d, rdata2_d;
    logic              wr_err_q, err_sticky_q;

    logic sel_onehot;
    logic wr_valid;
    logic wr_bad;

    // Classify the select: exactly one bit set means (x & (x-1)) == 0 and x != 0.
    always_comb begin
        sel_onehot = (wsel != '0) && ((wsel & (wsel - SelOne)) == '0);
        wr_bad     = we && !sel_onehot;
        // A write to register 0 is legal but has no effect.
        wr_valid   = we && sel_onehot && !wsel[0];
    end

    // Next read data: old contents, or write-through when bypass is built in.
    always_comb begin
        rdata1_d = (raddr1 == '0) ? '0 : regs_q[raddr1];
        rdata2_d = (raddr2 == '0) ? '0 : regs_q[raddr2];
`ifdef REGFILE_WRITE_BYPASS_EN
        if (wr_valid && wsel[raddr1] && (raddr1 != '0)) begin
            rdata1_d = wdata;
        end
        if (wr_valid && wsel[raddr2] && (raddr2 != '0)) begin
            rdata2_d = wdata;
        end
`endif
    end

    // Register array: only a validated one-hot select writes, never register 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (wr_valid) begin
            for (int i = 1; i < NREGS; i++) begin
                if (wsel[i]) begin
                    regs_q[i] <= wdata;
                end
            end
        end
    end

    // Registered read ports, one cycle latency.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata1_q <= '0;
            rdata2_q <= '0;
        end else begin
            rdata1_q <= rdata1_d;
            rdata2_q <= rdata2_d;
        end
    end

    // Error pulse and sticky flag; a new error beats a simultaneous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_err_q     <= 1'b0;
            err_sticky_q <= 1'b0;
        end else begin
            wr_err_q <= wr_bad;
            if (wr_bad) begin
                err_sticky_q <= 1'b1;
            end else if (err_clr) begin
                err_sticky_q <= 1'b0;
            end
        end
    end

    assign rdata1     = rdata1_q;
    assign rdata2     = rdata2_q;
    assign wr_err     = wr_err_q;
    assign err_sticky = err_sticky_q;

endmodule
